// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
// Shares one bit-serial adder between two requesters. A round-robin arbiter
// grants the adder, the winner's operands are captured at the grant edge and
// added LSB-first over W cycles. The W-bit sum, the carry-out and a one-cycle
// done pulse are returned to the owner. All handshake outputs are registered.

module serial_add_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Mrst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry: majority of the three inputs.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t        state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          c_r;
  logic [CW-1:0] cnt_r;
  // Owner of the current/last add. Because the owner is always the most
  // recently served requester, it doubles as the round-robin pointer.
  logic          owner_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          done0_r;
  logic          done1_r;
  logic          busy_r;

  logic          any_req_s;
  logic          win_s;
  logic          bit_s;
  logic          carry_s;

  // Arbitration winner and the serial full-adder slice.
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      win_s = ~owner_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    bit_s   = fa_sum(a_r[0], b_r[0], c_r);
    carry_s = fa_carry(a_r[0], b_r[0], c_r);
  end

  // Sequencer: grant, W shift cycles, one done cycle, back to idle.
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      owner_r <= 1'b1;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= SHIFT;
            owner_r <= win_s;
            a_r     <= win_s ? a1 : a0;
            b_r     <= win_s ? b1 : b0;
            c_r     <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            gnt0_r  <= ~win_s;
            gnt1_r  <= win_s;
            busy_r  <= 1'b1;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            busy_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
          end
        end
        SHIFT: begin
          a_r   <= {1'b0, a_r[W-1:1]};
          b_r   <= {1'b0, b_r[W-1:1]};
          c_r   <= carry_s;
          sum_r <= {bit_s, sum_r[W-1:1]};
          if (cnt_r == CNT_LAST) begin
            // Last bit: the sum register is now complete.
            state_r <= DONE;
            cout_r  <= carry_s;
            done0_r <= ~owner_r;
            done1_r <= owner_r;
          end else begin
            state_r <= SHIFT;
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          busy_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          busy_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0  = gnt0_r;
  assign gnt1  = gnt1_r;
  assign done0 = done0_r;
  assign done1 = done1_r;
  assign sum   = sum_r;
  assign cout  = cout_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter with a cycle-level reference
// model: expected sums come from plain integer addition, expected handshake
// timing from the grant/done schedule and the round-robin rule.

module tb_serial_add_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         Mrst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, cout, busy;
  logic [W-1:0] sum;

  int checks;
  int passed;
  int fails;
  int last_served;

  serial_add_arbiter #(.W(W)) dut (
    .clk   (clk),
    .Mrst_n(Mrst_n),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tally(input bit ok);
    checks++;
    if (ok) passed++;
    else fails++;
  endtask

  // Compare {gnt0,gnt1,done0,done1,busy} against expectation.
  // Each call site performs its own comparison inline.

  task automatic test_reset();
    logic [4:0] act;
    Mrst_n = 1'b0;
    req0 = 1'($urandom);
    req1 = 1'($urandom);
    a0 = 8'($urandom); b0 = 8'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      act = {gnt0, gnt1, done0, done1, busy};
      if (act !== 5'b00000 || sum !== 8'h00 || cout !== 1'b0) begin
        $display("FAIL reset_hold: ctl=%b sum=%h cout=%b required ctl=00000 sum=00 cout=0", act, sum, cout);
        tally(1'b0);
      end else tally(1'b1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    Mrst_n = 1'b1;
    last_served = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      act = {gnt0, gnt1, done0, done1, busy};
      if (act !== 5'b00000) begin
        $display("FAIL reset_release_idle: ctl=%b required 00000", act);
        tally(1'b0);
      end else tally(1'b1);
    end
  endtask

  // One add by a single requester starting from IDLE. Optionally scrambles
  // the operands every cycle after grant and drops req in cycle 3.
  task automatic run_add(input int who, input logic [7:0] a, input logic [7:0] b,
                         input bit scramble, input string name);
    int         full;
    logic [4:0] exp_v, act_v;
    logic [7:0] exp_sum;
    logic       exp_cout;
    full     = int'(a) + int'(b);
    exp_sum  = 8'(full % 256);
    exp_cout = (full >= 256);
    if (who == 0) begin
      a0 = a; b0 = b; req0 = 1'b1;
    end else begin
      a1 = a; b1 = b; req1 = 1'b1;
    end
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      step();
      exp_v = {(cyc <= W + 1) && (who == 0), (cyc <= W + 1) && (who == 1),
               (cyc == W + 1) && (who == 0), (cyc == W + 1) && (who == 1),
               (cyc <= W + 1)};
      act_v = {gnt0, gnt1, done0, done1, busy};
      if (act_v !== exp_v) begin
        $display("FAIL %s_ctl cyc=%0d: ctl=%b required %b", name, cyc, act_v, exp_v);
        tally(1'b0);
      end else tally(1'b1);
      if (cyc >= W + 1) begin
        if (sum !== exp_sum || cout !== exp_cout) begin
          $display("FAIL %s_result cyc=%0d: sum=%h cout=%b required sum=%h cout=%b",
                   name, cyc, sum, cout, exp_sum, exp_cout);
          tally(1'b0);
        end else tally(1'b1);
      end
      if (scramble) begin
        if (who == 0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
        else begin a1 = 8'($urandom); b1 = 8'($urandom); end
        if (cyc == 3) begin
          if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        end
      end
      if (cyc == W + 1) begin
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    last_served = who;
  endtask

  task automatic test_single();
    run_add(0, 8'h35, 8'h4A, 1'b0, "single");
  endtask

  task automatic test_overflow();
    run_add(1, 8'hFF, 8'h01, 1'b0, "overflow");
    run_add(1, 8'hAA, 8'h55, 1'b0, "complement");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_add(int'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_tie();
    int         win [4];
    int         ptr;
    int         k, ph;
    logic [4:0] exp_v, act_v;
    logic [7:0] exp_sum;
    Mrst_n = 1'b0;
    #1;
    a0 = 8'h10; b0 = 8'h20; a1 = 8'h03; b1 = 8'h04;
    req0 = 1'b1; req1 = 1'b1;
    step();
    Mrst_n = 1'b1;
    // Both requesters always pending: the one not served last wins.
    ptr = 1;
    for (int i = 0; i < 4; i++) begin
      win[i] = (ptr == 0) ? 1 : 0;
      ptr = win[i];
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      k  = (cyc - 1) / (W + 2);
      ph = (cyc - 1) % (W + 2);
      if (k < 4 && ph <= W) begin
        exp_v = {win[k] == 0, win[k] == 1, (ph == W) && (win[k] == 0),
                 (ph == W) && (win[k] == 1), 1'b1};
      end else begin
        exp_v = 5'b00000;
      end
      act_v = {gnt0, gnt1, done0, done1, busy};
      if (act_v !== exp_v) begin
        $display("FAIL tie_ctl cyc=%0d: ctl=%b required %b", cyc, act_v, exp_v);
        tally(1'b0);
      end else tally(1'b1);
      if (ph >= W && k < 4) begin
        exp_sum = (win[k] == 0) ? 8'h30 : 8'h07;
        if (sum !== exp_sum || cout !== 1'b0) begin
          $display("FAIL tie_sum cyc=%0d: sum=%h cout=%b required sum=%h cout=0", cyc, sum, cout, exp_sum);
          tally(1'b0);
        end else tally(1'b1);
      end
      if (cyc == 39) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    last_served = win[3];
  endtask

  task automatic test_reset_mid();
    logic [4:0] act;
    a0 = 8'h5C; b0 = 8'h77; req0 = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) step();
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL midrst_pre: gnt0=%b busy=%b required 1 1", gnt0, busy);
      tally(1'b0);
    end else tally(1'b1);
    Mrst_n = 1'b0;
    #1;
    act = {gnt0, gnt1, done0, done1, busy};
    if (act !== 5'b00000 || sum !== 8'h00 || cout !== 1'b0) begin
      $display("FAIL midrst_async: ctl=%b sum=%h cout=%b required 00000 00 0", act, sum, cout);
      tally(1'b0);
    end else tally(1'b1);
    req0 = 1'b0;
    step();
    Mrst_n = 1'b1;
    last_served = 1;
    for (int i = 0; i < W + 4; i++) begin
      step();
      act = {gnt0, gnt1, done0, done1, busy};
      if (act !== 5'b00000) begin
        $display("FAIL midrst_idle i=%0d: ctl=%b required 00000", i, act);
        tally(1'b0);
      end else tally(1'b1);
    end
  endtask

  task automatic test_stability();
    run_add(0, 8'hC3, 8'h5E, 1'b1, "stability");
    run_add(1, 8'h81, 8'h92, 1'b1, "stability1");
  endtask

  task automatic test_back_to_back();
    // Requester 1 last served; single requester 0 twice, then alternate.
    run_add(0, 8'h01, 8'h02, 1'b0, "b2b_a");
    run_add(0, 8'hF0, 8'h10, 1'b0, "b2b_b");
    run_add(1, 8'h7F, 8'h7F, 1'b0, "b2b_c");
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    last_served = 1;
    Mrst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_overflow();
    test_random();
    test_tie();
    test_reset_mid();
    test_stability();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Shares one bit-serial adder between two requesters. It arbitrates round-robin, captures the winner's operands and sequences the add LSB-first over W cycles. It then returns the W-bit sum, the carry-out and a one-cycle completion pulse to the winner. It sits above the serial adder datapath and replaces per-client go/load/enable sequencing with a req/gnt/done handshake.

## Interface
- W, 8: operand and sum width in bits; W ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- Mrst_n  input  1  reset; asynchronous assert, active-low; synchronous deassert is the system's responsibility.
- req0, req1  input  1  level request from requester 0 / 1.
- a0, b0  input  W  operands of requester 0; sampled only at grant.
- a1, b1  input  W  operands of requester 1; sampled only at grant.
- gnt0, gnt1  output  1  requester owns the adder; one-hot or zero.
- done0, done1  output  1  one-cycle result-valid pulse to the owner.
- sum  output  W  result of the last completed add; held until the next grant.
- cout  output  1  carry-out of the last completed add.
- busy  output  1  high in SHIFT and DONE.

## Operation
- Registered state machine with three states: IDLE, SHIFT and DONE.
- IDLE:
  - If any req is high at the edge, pick a winner and go to SHIFT.
  - At that edge: load the winner's a/b into shift registers, clear the carry flop, clear the bit counter, set owner, clear sum/cout.
- SHIFT:
  - Each cycle, s = a[0] ^ b[0] ^ c; c ← majority(a[0], b[0], c).
  - a and b shift right by 1; s enters sum at the MSB and sum shifts right.
  - The counter increments.
  - On the edge where the counter == W−1, go to DONE. SHIFT therefore lasts exactly W cycles.
- DONE:
  - Lasts one cycle; done of the owner = 1.
  - sum holds the full W-bit result and cout the final carry.
  - Next state is IDLE unconditionally.
- Arithmetic: sum = (a + b) mod 2^W; cout = bit W of a + b. Unsigned.
- Arbitration:
  - A single requester is granted whenever seen in IDLE.
  - On a tie, the requester not served most recently wins.
  - The last-served pointer resets to "1", so req0 wins the first tie.
- Handshake:
  - A requester holds req until it sees done, then drops req by the next edge.
  - If req is still high in the following IDLE cycle, it is a new request (back-to-back allowed, subject to round-robin).
- req deasserted during SHIFT/DONE: ignored; the add completes and done still pulses.
- Operand changes after the grant edge: ignored.
- The counter never wraps in use; it is reloaded to 0 on every grant.

## Timing
- Reset (Mrst_n low), immediately and asynchronously:
  - state = IDLE; gnt0 = gnt1 = 0; done0 = done1 = 0; busy = 0.
  - sum = 0; cout = 0; counter = 0; pointer = 1.
- Reset mid-operation: the add is abandoned with no done pulse. After release, the block waits in IDLE for a fresh req.
- Latency, for req sampled in IDLE cycle 0:
  - gnt high in cycles 1..W+1.
  - busy high in cycles 1..W+1.
  - done high in cycle W+1 only.
  - sum/cout valid from cycle W+1 until the next grant.
- Throughput: one add per W+2 cycles with continuous requests (one IDLE cycle between adds).
- Outputs gnt, done and busy decode from registered state and owner; no combinational path from req.

## Test plan
- Reset values: drive Mrst_n = 0 with random req/operands -> all outputs 0. Release with req = 0 -> block stays IDLE, busy = 0.
- Single add: W = 8, req0 = 1 with a0 = 8'h35, b0 = 8'h4A in cycle 0 -> gnt0 in cycles 1–9, done0 in cycle 9 only, sum = 8'h7F, cout = 0, gnt1 never high.
- Overflow: req1 with a1 = 8'hFF, b1 = 8'h01 -> done1 in cycle 9, sum = 8'h00, cout = 1. Then a1 = 8'hAA, b1 = 8'h55 -> sum = 8'hFF, cout = 0.
- Tie and round-robin:
  - Stimulus: req0 and req1 both held high from reset; a0 = 8'h10, b0 = 8'h20; a1 = 8'h03, b1 = 8'h04.
  - Required: grants alternate 0, 1, 0, 1; done pulses at cycles 9, 19, 29, 39; sums alternate 8'h30 and 8'h07.
- Reset mid-SHIFT: start req0 add, pull Mrst_n low in cycle 4 -> gnt0, busy and sum drop at once, no done0 pulse. Release with req0 = 0 -> block stays IDLE.
- Stability: after the grant, change a0/b0 every cycle and drop req0 in cycle 3 -> done0 still pulses in cycle 9, and sum equals the operands captured at grant.
